// File: rtl/sonic_echo_emulator.sv
// HC-SR04 responder: answers an accepted Trig pulse with an Echo pulse
// whose width encodes a programmed distance (58 us/cm convention).
module sonic_echo_emulator #(
    parameter int CYC_PER_US  = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int CYC_PER_CM  = 5800,
    parameter int MIN_CM      = 2,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [9:0] dist_cm,
    input  logic       no_obj,
    output logic       echo,
    output logic       busy,
    output logic       short_trig
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG_HI, S_BURST, S_ECHO, S_HOLDOFF
    } state_t;

    localparam logic [21:0] CNT_MAX    = '1;
    localparam logic [21:0] TRIG_MIN_C = 22'(TRIG_MIN_US * CYC_PER_US);
    localparam logic [21:0] BURST_C    = 22'(BURST_US * CYC_PER_US);
    localparam logic [21:0] HOLD_C     = 22'(HOLDOFF_US * CYC_PER_US);
    localparam logic [21:0] TOUT_C     = 22'(TIMEOUT_US * CYC_PER_US);
    localparam logic [9:0]  MIN_C      = 10'(MIN_CM);
    localparam logic [9:0]  MAX_C      = 10'(MAX_CM);

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic [1:0]  warm_q, warm_d;
    logic        armed_q, armed_d;
    logic [21:0] cnt_q, cnt_d;
    logic [9:0]  dist_q, dist_d;
    logic        noobj_q, noobj_d;
    logic        echo_q, echo_d;
    logic        short_q, short_d;

    logic        trig_s, rise, fall;
    logic [21:0] cnt_inc, width;
    logic [9:0]  dist_eff;
    logic [22:0] prod;

    assign trig_s  = sync_q[1];
    // A rise only counts once a genuine low has been seen since reset
    assign rise    = trig_s & ~sync_q[2] & armed_q;
    assign fall    = ~trig_s & sync_q[2];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 22'd1;

    assign dist_eff = (dist_q < MIN_C) ? MIN_C : dist_q;
    assign prod     = 23'(dist_eff) * 23'(CYC_PER_CM);
    assign width    = (noobj_q || dist_q > MAX_C) ? TOUT_C : prod[21:0];

    assign echo       = echo_q;
    assign short_trig = short_q;
    assign busy       = (state_q == S_BURST) || (state_q == S_ECHO) ||
                        (state_q == S_HOLDOFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            warm_q  <= '0;
            armed_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dist_q  <= '0;
            noobj_q <= 1'b0;
            echo_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], trig};
            warm_q  <= warm_d;
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            noobj_q <= noobj_d;
            echo_q  <= echo_d;
            short_q <= short_d;
        end
    end

    always_comb begin
        warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd2) & ~trig_s);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        noobj_d = noobj_q;
        echo_d  = echo_q;
        short_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_TRIG_HI;
                    cnt_d   = 22'd1;
                end
            end
            S_TRIG_HI: begin
                if (fall) begin
                    cnt_d = '0;
                    if (cnt_q >= TRIG_MIN_C) begin
                        dist_d  = dist_cm;
                        noobj_d = no_obj;
                        state_d = S_BURST;
                    end else begin
                        short_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (trig_s) begin
                    cnt_d = cnt_inc;
                end
            end
            S_BURST: begin
                if (cnt_q >= BURST_C - 22'd1) begin
                    echo_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_ECHO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ECHO: begin
                if (cnt_q >= width - 22'd1) begin
                    echo_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_HOLDOFF;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q >= HOLD_C - 22'd1) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                echo_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Directed bench for sonic_echo_emulator with shortened timing parameters.
module tb_sonic_echo_emulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       trig;
    logic [9:0] dist_cm;
    logic       no_obj;
    logic       echo;
    logic       busy;
    logic       short_trig;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_short = 0;
    int n_rise  = 0;
    logic echo_prev = 1'b0;

    sonic_echo_emulator #(
        .CYC_PER_US (1),
        .TRIG_MIN_US(10),
        .BURST_US   (5),
        .CYC_PER_CM (58),
        .MIN_CM     (2),
        .MAX_CM     (400),
        .TIMEOUT_US (300),
        .HOLDOFF_US (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .dist_cm   (dist_cm),
        .no_obj    (no_obj),
        .echo      (echo),
        .busy      (busy),
        .short_trig(short_trig)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (short_trig) n_short++;
        if (echo && !echo_prev) n_rise++;
        echo_prev = echo;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        trig = 1'b1;
        repeat (n) tick();
        trig = 1'b0;
    endtask

    task automatic wait_echo(input logic lvl, output int k);
        k = 0;
        while (k < 40000 && echo !== lvl) begin
            tick();
            k++;
        end
    endtask

    task automatic run_echo(input string tag, input int hi, input int exp_w);
        int d, w, h;
        pulse(hi);
        d = 0;
        while (d < 100) begin
            tick();
            d++;
            if (echo) break;
        end
        check({tag, "_lat"}, d, 8);
        check({tag, "_busy"}, int'(busy), 1);
        w = 1;
        while (w < 40000) begin
            tick();
            if (!echo) break;
            w++;
        end
        check({tag, "_width"}, w, exp_w);
        h = 0;
        while (h < 100) begin
            tick();
            h++;
            if (!busy) break;
        end
        check({tag, "_hold"}, h, 20);
        repeat (3) tick();
    endtask

    task automatic run_short(input string tag, input int hi);
        int bs, br;
        logic seen;
        bs   = n_short;
        br   = n_rise;
        seen = 1'b0;
        pulse(hi);
        repeat (30) begin
            tick();
            if (busy) seen = 1'b1;
        end
        check({tag, "_pulses"}, n_short - bs, 1);
        check({tag, "_echo"}, n_rise - br, 0);
        check({tag, "_busy"}, int'(seen), 0);
    endtask

    initial begin
        int k, bs, br;
        rst     = 1'b1;
        trig    = 1'b0;
        dist_cm = 10'd30;
        no_obj  = 1'b0;
        repeat (3) tick();
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_short", int'(short_trig), 0);
        rst = 1'b0;
        repeat (6) tick();

        bs = n_short;
        run_echo("d30", 12, 1740);
        check("d30_noshort", n_short - bs, 0);

        run_short("short5", 5);
        run_short("short9", 9);

        dist_cm = 10'd0;
        run_echo("t10_d0", 10, 116);
        dist_cm = 10'd30;
        no_obj  = 1'b1;
        run_echo("noobj", 12, 300);
        no_obj  = 1'b0;
        dist_cm = 10'd401;
        run_echo("d401", 12, 300);
        dist_cm = 10'd400;
        run_echo("d400", 12, 23200);

        // Retriggers during ECHO and HOLDOFF must be dropped
        dist_cm = 10'd3;
        bs = n_short;
        br = n_rise;
        pulse(12);
        wait_echo(1'b1, k);
        repeat (20) tick();
        dist_cm = 10'd100;
        pulse(12);
        wait_echo(1'b0, k);
        pulse(12);
        k = 0;
        while (k < 200 && busy) begin
            tick();
            k++;
        end
        repeat (5) tick();
        check("ign_echoes", n_rise - br, 1);
        check("ign_short", n_short - bs, 0);
        dist_cm = 10'd3;
        run_echo("after_ign", 12, 174);

        dist_cm = 10'd30;
        pulse(12);
        wait_echo(1'b1, k);
        repeat (50) tick();
        trig = 1'b1;
        rst  = 1'b1;
        #1;
        check("rst_mid_echo", int'(echo), 0);
        check("rst_mid_busy", int'(busy), 0);
        repeat (2) tick();
        rst = 1'b0;
        br  = n_rise;
        repeat (60) tick();
        check("lvl_hi_echo", n_rise - br, 0);
        check("lvl_hi_busy", int'(busy), 0);
        trig = 1'b0;
        repeat (10) tick();
        check("lvl_drop_echo", n_rise - br, 0);
        check("lvl_drop_busy", int'(busy), 0);
        dist_cm = 10'd2;
        run_echo("fresh", 12, 116);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
